// File: rtl/inst_seq_ctrl.sv
// inst_seq_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC, with halt logic and cycle/instret counters
module inst_seq_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            ifu_req_o,
  output logic [XLEN-1:0] ifu_addr_o,
  input  logic [31:0]     ifu_rdata_i,
  input  logic            ifu_rvalid_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_is_lsu_i,
  input  logic            dec_rd_wen_i,
  input  logic            dec_ebreak_i,
  input  logic            dec_illegal_i,
  input  logic [XLEN-1:0] exu_next_pc_i,
  output logic            lsu_req_o,
  input  logic            lsu_done_i,
  output logic            rf_wen_o,
  output logic            halt_o,
  output logic [1:0]      halt_cause_o,
  output logic [63:0]     mcycle_o,
  output logic [63:0]     minstret_o
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic [1:0] cause_nx;
  logic [WW-1:0] wait_cnt;
  logic at_limit, waiting;
  assign at_limit   = wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign ifu_req_o  = state == FETCH;
  assign lsu_req_o  = state == MEM;
  assign rf_wen_o   = state == WB && dec_rd_wen_i;
  assign halt_o     = state == HALT;
  assign ifu_addr_o = pc_o;
  // a response arriving on the limit cycle takes priority over the timeout
  always_comb begin
    state_nx = state;
    cause_nx = halt_cause_o;
    case (state)
      FETCH: begin
        state_nx = ifu_rvalid_i ? DECODE : at_limit ? HALT : FETCH;
        cause_nx = !ifu_rvalid_i && at_limit ? 2'b11 : halt_cause_o;
      end
      DECODE: begin
        state_nx = dec_ebreak_i || dec_illegal_i ? HALT : EXEC;
        cause_nx = dec_ebreak_i ? 2'b01 : dec_illegal_i ? 2'b10 : halt_cause_o;
      end
      EXEC: state_nx = dec_is_lsu_i ? MEM : WB;
      MEM: begin
        state_nx = lsu_done_i ? WB : at_limit ? HALT : MEM;
        cause_nx = !lsu_done_i && at_limit ? 2'b11 : halt_cause_o;
      end
      WB: state_nx = FETCH;
      default: ;
    endcase
  end
  // wait_cnt counts only while staying in a waiting state, so any entry clears it
  assign waiting = (state == FETCH || state == MEM) && state_nx == state;
  // state, PC, instruction latch, wait counter and performance counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= FETCH;
      halt_cause_o <= 2'b00;
      pc_o         <= RESET_PC;
      inst_o       <= '0;
      wait_cnt     <= '0;
      mcycle_o     <= '0;
      minstret_o   <= '0;
    end else begin
      state        <= state_nx;
      halt_cause_o <= cause_nx;
      wait_cnt     <= waiting ? wait_cnt + 1'b1 : '0;
      if (state == FETCH && ifu_rvalid_i) inst_o <= ifu_rdata_i;
      if (state == WB) pc_o <= exu_next_pc_i;
      if (state == WB) minstret_o <= minstret_o + 64'd1;
      if (state != HALT) mcycle_o <= mcycle_o + 64'd1;
    end
  end
endmodule

// File: tb/tb_inst_seq_ctrl.sv
// tb_inst_seq_ctrl: randomized transaction-level check of the instruction sequencer
module tb_inst_seq_ctrl;
  localparam int TO = 8;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req, ifu_rvalid, is_lsu, rd_wen, ebreak, illegal, lsu_req, lsu_done, rf_wen, halt;
  logic [31:0] ifu_addr, ifu_rdata, inst, pc, next_pc;
  logic [1:0] cause;
  logic [63:0] mcycle, minstret;
  int vecs = 0, errs = 0;
  logic [31:0] pc_m, inst_m;
  logic [63:0] mcyc_m, mret_m;
  always #5 clk = ~clk;
  inst_seq_ctrl #(.XLEN(32), .RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ifu_req_o(ifu_req), .ifu_addr_o(ifu_addr),
    .ifu_rdata_i(ifu_rdata), .ifu_rvalid_i(ifu_rvalid), .inst_o(inst), .pc_o(pc),
    .dec_is_lsu_i(is_lsu), .dec_rd_wen_i(rd_wen), .dec_ebreak_i(ebreak),
    .dec_illegal_i(illegal), .exu_next_pc_i(next_pc), .lsu_req_o(lsu_req),
    .lsu_done_i(lsu_done), .rf_wen_o(rf_wen), .halt_o(halt), .halt_cause_o(cause),
    .mcycle_o(mcycle), .minstret_o(minstret)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic junk_dec();
    is_lsu = 1'($urandom); rd_wen = 1'($urandom); ebreak = 1'($urandom);
    illegal = 1'($urandom); next_pc = $urandom;
  endtask
  task automatic cyc(input logic e_ifu, input logic e_lsu, input logic e_wen, input logic e_halt);
    #1;
    check("ifu_req", ifu_req, e_ifu);
    check("lsu_req", lsu_req, e_lsu);
    check("rf_wen", rf_wen, e_wen);
    check("halt", halt, e_halt);
    check("pc", pc, pc_m);
    if (e_ifu) check("ifu_addr", ifu_addr, pc_m);
    if (!e_halt) mcyc_m++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; ifu_rvalid = 1'b0; lsu_done = 1'b0; ifu_rdata = $urandom; junk_dec();
    @(negedge clk);
    check("rst_ifu_req", ifu_req, 1);
    check("rst_lsu_req", lsu_req, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_halt", halt, 0);
    check("rst_cause", cause, 0);
    check("rst_pc", pc, RPC);
    check("rst_inst", inst, 0);
    check("rst_mcycle", mcycle, 0);
    check("rst_minstret", minstret, 0);
    rst_n = 1'b1;
    pc_m = RPC; mcyc_m = 0; mret_m = 0; inst_m = 0;
  endtask
  task automatic halt_check(input logic [1:0] c);
    for (int i = 0; i < 3; i++) begin
      ifu_rvalid = 1'($urandom); lsu_done = 1'($urandom); junk_dec();
      cyc(0, 0, 0, 1);
      check("halt_cause", cause, c);
      check("halt_mcycle", mcycle, mcyc_m);
      check("halt_minstret", minstret, mret_m);
    end
    do_reset();
  endtask
  // kind: 0 alu+rd 1 alu 2 load 3 store 4 ebreak 5 illegal 6 ebreak+illegal 7 load with reset in MEM
  task automatic run_instr(input int kind, input int df, input int dm);
    logic [31:0] w, npc;
    logic rd, lsu, eb, il;
    w = kind == 4 ? 32'h0010_0073 : $urandom;
    npc = $urandom & 32'hffff_fffc;
    rd = kind == 0 || kind == 2 || kind == 7;
    lsu = kind == 2 || kind == 3 || kind == 7;
    eb = kind == 4 || kind == 6;
    il = kind == 5 || kind == 6;
    for (int i = 0; i < TO; i++) begin
      ifu_rvalid = i == df; ifu_rdata = i == df ? w : $urandom; lsu_done = 1'($urandom); junk_dec();
      cyc(1, 0, 0, 0);
      if (i == df) break;
    end
    if (df >= TO) begin
      halt_check(2'b11);
      return;
    end
    inst_m = w;
    is_lsu = lsu; rd_wen = rd; ebreak = eb; illegal = il; next_pc = npc;
    ifu_rvalid = 1'($urandom); ifu_rdata = $urandom; lsu_done = 1'($urandom);
    check("inst_dec", inst, inst_m);
    cyc(0, 0, 0, 0);
    if (eb || il) begin
      halt_check(eb ? 2'b01 : 2'b10);
      return;
    end
    ifu_rvalid = 1'($urandom); lsu_done = 1'($urandom);
    check("inst_exec", inst, inst_m);
    cyc(0, 0, 0, 0);
    if (kind == 7) begin
      lsu_done = 1'b0;
      #1 check("mem_lsu_req", lsu_req, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_lsu_req", lsu_req, 0);
      check("async_pc", pc, RPC);
      check("async_mcycle", mcycle, 0);
      check("async_minstret", minstret, 0);
      check("async_rf_wen", rf_wen, 0);
      do_reset();
      return;
    end
    if (lsu) begin
      for (int i = 0; i < TO; i++) begin
        lsu_done = i == dm; ifu_rvalid = 1'($urandom); ifu_rdata = $urandom;
        check("inst_mem", inst, inst_m);
        cyc(0, 1, 0, 0);
        if (i == dm) break;
      end
      if (dm >= TO) begin
        halt_check(2'b11);
        return;
      end
    end
    lsu_done = 1'($urandom); ifu_rvalid = 1'($urandom);
    check("inst_wb", inst, inst_m);
    cyc(0, 0, rd, 0);
    pc_m = npc; mret_m++;
    check("minstret", minstret, mret_m);
    check("mcycle", mcycle, mcyc_m);
    check("pc_next", pc, pc_m);
  endtask
  initial begin
    ifu_rvalid = 1'b0; lsu_done = 1'b0; ifu_rdata = '0; junk_dec();
    pc_m = RPC; mcyc_m = 0; mret_m = 0; inst_m = 0;
    @(negedge clk);
    do_reset();
    run_instr(0, 1, 0);
    run_instr(2, 0, 2);
    run_instr(3, 2, 0);
    run_instr(1, 0, 0);
    run_instr(4, 0, 0);
    run_instr(0, TO, 0);
    run_instr(0, TO - 1, 0);
    run_instr(2, 0, TO - 1);
    run_instr(3, 1, TO);
    run_instr(5, 0, 0);
    run_instr(6, 3, 0);
    run_instr(7, 0, 0);
    for (int n = 0; n < 200; n++) begin
      int r, k, df, dm;
      r = $urandom_range(0, 99);
      k = r < 90 ? $urandom_range(0, 3) : r < 97 ? $urandom_range(4, 6) : 7;
      df = $urandom_range(0, 19) == 0 ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      dm = $urandom_range(0, 19) == 0 ? TO : $urandom_range(0, TO - 1);
      run_instr(k, df, dm);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
